// File: rtl/rst_seq.sv
// rst_seq: reset sequencer with async assertion, synchronised staggered release and masked software re-reset.
module rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] rst_out_n,
    output logic              seq_busy,
    output logic              seq_done
);
    typedef enum logic [2:0] {SYNC, HOLD, REL, RUN, SW_HOLD, SW_REL} state_t;
    state_t            state, state_d;
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]  cnt, cnt_d, lim;
    logic [NUM_CH-1:0] held, held_d;
    logic              in_hold, sw_path;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            state <= SYNC;
            cnt   <= '0;
            held  <= '1;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], 1'b1};
            state <= state_d;
            cnt   <= cnt_d;
            held  <= held_d;
        end
    end
    assign in_hold = (state == HOLD) || (state == SW_HOLD);
    assign sw_path = (state == SW_HOLD) || (state == SW_REL);
    assign lim     = in_hold ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(STAGGER - 1);
    // held doubles as the pending-release set; each release clears its lowest set bit
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        held_d  = held;
        case (state)
            SYNC: begin
                state_d = sync[SYNC_STAGES-1] ? HOLD : SYNC;
                cnt_d   = '0;
            end
            HOLD, REL, SW_HOLD, SW_REL: begin
                held_d  = (cnt == lim) ? (held & (held - NUM_CH'(1))) : held;
                cnt_d   = (cnt == lim) ? '0 : cnt + CNT_W'(1);
                state_d = (cnt != lim) ? state : !(|held_d) ? RUN : sw_path ? SW_REL : REL;
            end
            RUN: begin
                held_d  = (sw_rst_req && |ch_mask) ? ch_mask : held;
                state_d = (sw_rst_req && |ch_mask) ? SW_HOLD : RUN;
                cnt_d   = '0;
            end
            default: state_d = SYNC;
        endcase
    end
    assign rst_out_n = ~held;
    assign seq_done  = (state == RUN);
    assign seq_busy  = !seq_done;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: table-driven scoreboard bench for rst_seq, default and minimal parameter sets.
module tb_rst_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw = 1'b0;
    logic [3:0] mask = '0;
    logic [3:0] ro;
    logic       busy, done;
    logic [0:0] ro1;
    logic       busy1, done1;
    int         checks = 0;
    int         failures = 0;
    int         ec = 0;

    typedef struct {
        int         e;
        logic       sw;
        logic [3:0] mask;
        logic [3:0] ro;
        logic       done;
        logic       busy;
        logic       ro1;
        logic       done1;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] ro;
        logic       done;
        logic       busy;
        logic       ro1;
        logic       done1;
    } exp_t;

    exp_t sb[$];

    rst_seq dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw), .ch_mask(mask),
        .rst_out_n(ro), .seq_busy(busy), .seq_done(done)
    );

    rst_seq #(.SYNC_STAGES(3), .NUM_CH(1), .HOLD_CYCLES(1), .STAGGER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw), .ch_mask(mask[0:0]),
        .rst_out_n(ro1), .seq_busy(busy1), .seq_done(done1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic push(string name, logic [3:0] r, logic d, logic b, logic r1, logic d1);
        exp_t x;
        x.name = name; x.ro = r; x.done = d; x.busy = b; x.ro1 = r1; x.done1 = d1;
        sb.push_back(x);
    endtask

    task automatic chk();
        exp_t x;
        x = sb.pop_front();
        checks++;
        if ({ro, done, busy, ro1, done1} !== {x.ro, x.done, x.busy, x.ro1, x.done1}) begin
            failures++;
            $display("FAIL %s edge=%0d got ro=%b done=%b busy=%b ro1=%b done1=%b want ro=%b done=%b busy=%b ro1=%b done1=%b",
                     x.name, ec, ro, done, busy, ro1, done1, x.ro, x.done, x.busy, x.ro1, x.done1);
        end
    endtask

    task automatic apply(string name, vec_t v);
        while (ec < v.e - 1) step();
        sw = v.sw;
        mask = v.mask;
        step();
        sw = 1'b0;
        push($sformatf("%s@%0d", name, v.e), v.ro, v.done, v.busy, v.ro1, v.done1);
        chk();
    endtask

    vec_t pon[$];
    vec_t swr[$];

    task automatic power_on(string name);
        foreach (pon[i]) apply(name, pon[i]);
    endtask

    initial begin
        // edge, sw, mask, ro, done, busy, ro1, done1
        pon = '{
            '{1,  1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0},
            '{4,  1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0},
            '{5,  1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1},
            '{18, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1},
            '{19, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1},
            '{26, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1},
            '{27, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b1},
            '{30, 1'b1, 4'b1111, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0},
            '{34, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b1},
            '{35, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b1},
            '{42, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b1},
            '{43, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1},
            '{48, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1}
        };
        // software reset at R=60 with mask 1010; mask swapped to 0101 after R; mask-0 request at 90
        swr = '{
            '{60, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1},
            '{61, 1'b0, 4'b0101, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1},
            '{75, 1'b0, 4'b0101, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1},
            '{76, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b1},
            '{83, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b1},
            '{84, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1},
            '{90, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1},
            '{91, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1}
        };

        repeat (5) step();
        push("reset_state", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk();
        rst_n = 1'b1;
        ec = 0;
        power_on("pon");

        // short glitch between edges: outputs assert with no clock edge
        #3 rst_n = 1'b0;
        #1 push("glitch_assert", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk();
        #1 rst_n = 1'b1;
        ec = 0;
        power_on("replay");

        foreach (swr[i]) apply("swrst", swr[i]);

        apply("mid_req", '{100, 1'b1, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1});
        apply("mid_hold", '{105, 1'b0, 4'b0000, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1});
        rst_n = 1'b0;
        #1 push("mid_assert", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk();
        repeat (3) step();
        push("mid_held", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk();
        rst_n = 1'b1;
        ec = 0;
        power_on("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
